// File: rtl/spoofer_checker_avst.sv
`default_nettype none
// ============================================================================
// Module   : spoofer_checker_avst
// Brief    : Avalon-ST sink that checks an incrementing counter stream, with
//            optional LFSR backpressure, saturating counters and first-error capture.
// Revision : 1.0 - initial release
// ============================================================================
module spoofer_checker_avst #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  stall_en_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  locked_o,
  output logic                  error_o,
  output logic [CNT_WIDTH-1:0]  beat_count_o,
  output logic [CNT_WIDTH-1:0]  error_count_o,
  output logic [DATA_WIDTH-1:0] first_err_expected_o,
  output logic [DATA_WIDTH-1:0] first_err_actual_o
);

  localparam logic [1:0]            S_IDLE    = 2'd0;
  localparam logic [1:0]            S_SYNC    = 2'd1;
  localparam logic [1:0]            S_TRACK   = 2'd2;
  localparam logic [15:0]           LFSR_SEED = 16'hACE1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  errc_q, errc_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] cap_exp_q, cap_exp_d;
  logic [DATA_WIDTH-1:0] cap_act_q, cap_act_d;

  logic xfer;
  logic lfsr_fb;

  assign xfer    = valid_i & ready_q;
  // Fibonacci taps 16,14,13,11 in right-shift form: bits 0,2,3,5 feed bit 15
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; clear overrides a transfer in the same cycle
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = enable_i ? S_SYNC : S_IDLE;
    end else if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_SYNC;
        S_SYNC:  if (xfer) state_d = S_TRACK;
        S_TRACK: state_d = S_TRACK;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    locked_o = (state_q == S_TRACK);
  end

  always_comb begin
    lfsr_d  = stall_en_i ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
    ready_d = enable_i & ~(stall_en_i & lfsr_q[0]);
  end

  always_comb begin
    expected_d = expected_q;
    beat_d     = beat_q;
    errc_d     = errc_q;
    error_d    = error_q;
    cap_exp_d  = cap_exp_q;
    cap_act_d  = cap_act_q;
    if (clear_i) begin
      beat_d    = '0;
      errc_d    = '0;
      error_d   = 1'b0;
      cap_exp_d = '0;
      cap_act_d = '0;
    end else if (xfer && state_q == S_SYNC) begin
      expected_d = data_i + DATA_ONE;
      beat_d     = sat_inc(beat_q);
    end else if (xfer && state_q == S_TRACK) begin
      beat_d     = sat_inc(beat_q);
      expected_d = data_i + DATA_ONE;
      if (data_i != expected_q) begin
        errc_d  = sat_inc(errc_q);
        error_d = 1'b1;
        if (!error_q) begin
          cap_exp_d = expected_q;
          cap_act_d = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= LFSR_SEED;
      ready_q    <= 1'b0;
      expected_q <= '0;
      beat_q     <= '0;
      errc_q     <= '0;
      error_q    <= 1'b0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      ready_q    <= ready_d;
      expected_q <= expected_d;
      beat_q     <= beat_d;
      errc_q     <= errc_d;
      error_q    <= error_d;
      cap_exp_q  <= cap_exp_d;
      cap_act_q  <= cap_act_d;
    end
  end

  assign ready_o              = ready_q;
  assign error_o              = error_q;
  assign beat_count_o         = beat_q;
  assign error_count_o        = errc_q;
  assign first_err_expected_o = cap_exp_q;
  assign first_err_actual_o   = cap_act_q;

endmodule
`default_nettype wire

// File: doc/spoofer_checker_avst.md
# spoofer_checker_avst

Avalon-ST sink that sits directly downstream of the spoofer AVST source and consumes its counter stream. It drives `ready` with optional pseudo-random backpressure and checks that every accepted beat equals the previous accepted beat plus one. It counts beats and sequence errors and captures the first mismatch, giving the spoofer path a self-checking endpoint on hardware and in simulation.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the stream data word
- `CNT_WIDTH`, 16, width of the beat and error counters

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  arms the checker; 0 forces `ready` low
- `stall_en`  in  1  enables LFSR-driven backpressure
- `clear`  in  1  one-cycle pulse; clears counters and capture, forces resync
- `valid`  in  1  source beat valid
- `data`  in  DATA_WIDTH  source beat data
- `ready`  out  1  sink ready (registered)
- `locked`  out  1  high in TRACK state
- `error`  out  1  sticky; set on first mismatch
- `beat_count`  out  CNT_WIDTH  accepted beats, saturating
- `error_count`  out  CNT_WIDTH  mismatches, saturating
- `first_err_expected`  out  DATA_WIDTH  expected value at first mismatch
- `first_err_actual`  out  DATA_WIDTH  received value at first mismatch

## Operation
- Transfer: `valid && ready` in the same cycle. No other cycle consumes data.
- States:
  - IDLE: `ready` stays low. Goes to SYNC when `enable`=1.
  - SYNC: the first transfer loads `expected <= data+1`, increments `beat_count`, no check, then goes to TRACK.
  - TRACK: on each transfer, compare `data` with `expected`.
    - Match: `expected <= expected+1`.
    - Mismatch: `error_count++`, set `error`. On the first error only, capture `expected` and `data`. Then resync with `expected <= data+1`, so one dropped beat costs exactly one error.
    - Every transfer increments `beat_count`.
  - Any state with `enable`=0: next state is IDLE. Counters and capture are held. Re-enabling enters SYNC.
- Arithmetic:
  - `expected` wraps modulo 2^DATA_WIDTH, so all-ones followed by 0 is a match.
  - Counters saturate at all-ones and do not wrap.
- Backpressure:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
  - Advances every cycle that `stall_en`=1; holds otherwise.
  - Next `ready` = `enable && !(stall_en && lfsr[0])`.
- `clear`:
  - Zeroes `beat_count`, `error_count`, `error` and both capture registers.
  - State goes to SYNC if `enable`=1, else IDLE.
  - A transfer in the same cycle as `clear` is consumed but neither counted nor checked. `clear` wins.
- `rst`:
  - Resets outputs: `ready`=0, `locked`=0, `error`=0, all counters and captures 0.
  - State IDLE, LFSR = seed.
  - Valid mid-stream. A beat presented during reset is not consumed, because `ready` is 0.

## Timing
- `ready` is registered. `enable` rising at cycle N gives `ready`=1 at N+1. `enable` falling at N gives `ready`=0 at N+1. A transfer at N itself still completes.
- Transfer at cycle T:
  - `beat_count`, `error_count`, `error`, captures and `locked` update at T+1.
  - Check latency is 1 cycle.
- Throughput: one beat per cycle while `ready` is high. The checker never stalls internally.
- `locked` rises the cycle after the SYNC transfer. It falls the cycle after `enable`=0, `clear` or `rst`.
- Error priority in one cycle: `rst` > `clear` > transfer.

## Test plan
- Reset, `enable`=1, no stall, source sends 5,6,7,8 on consecutive cycles:
  - `ready`=1 one cycle after `enable`.
  - `beat_count`=4, `error_count`=0, `locked`=1, `error`=0.
- Sequence 10,11,13,14:
  - `error_count`=1, `error`=1.
  - `first_err_expected`=12, `first_err_actual`=13.
  - `beat_count`=4, no further errors after 14.
- `DATA_WIDTH`=8, sequence 8'hFE,8'hFF,8'h00,8'h01: `error_count`=0. This checks wrap-around.
- `stall_en`=1 with `valid` held high for 200 cycles:
  - `ready` pattern matches a reference LFSR model from seed 16'hACE1.
  - `beat_count` equals the number of `ready`-high cycles.
  - `error_count`=0 against the spoofer source.
- Mid-stream events:
  - `clear` pulse mid-stream during a transfer: that beat is not counted, counters are 0 the next cycle, the next beat resyncs, and `error` stays 0.
  - `rst` asserted mid-stream: all outputs are 0 the next cycle.
- `CNT_WIDTH`=4, 20 error beats: `error_count` saturates at 4'hF.
- `enable` dropped after 3 beats, then re-enabled with a sequence jump 3→100:
  - Counts are held while disabled.
  - The re-sync beat 100 causes no error, and `beat_count`=4.
